div16: RTL
==========

# div16

Sequential 16-bit unsigned restoring divider for the ALU datapath, the inverse of the shift-add multiplier. The ALU sets `op` to the divide code and holds it. The block then samples `a` (dividend) and `b` (divisor) and runs one quotient bit per clock. It presents `{remainder, quotient}` on `out` with `ready` high until the ALU releases `op`.

## Interface
- No parameters; all widths are fixed at 16-bit operands and a 32-bit result.
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- op  input  2  ALU operation code; divide is selected when op == 2'b11 (div_op).
- a  input  16  dividend, unsigned; sampled only on the load edge.
- b  input  16  divisor, unsigned; sampled only on the load edge.
- out  output  32  {remainder[15:0], quotient[15:0]} while in DONE; 32'h0 otherwise.
- ready  output  1  (state == DONE) & div_op & ~reset.

## Operation
- Registers:
  - state: IDLE, RUN or DONE.
  - count: 5 bits.
  - divisor_r: 16 bits.
  - quot_r: 16 bits; shifts in quotient bits and initially holds the dividend.
  - rem_r: 17 bits, the partial remainder.
- Reset (async): state = IDLE, count = 0, all data registers = 0. Consequently out = 0 and ready = 0 immediately.
- IDLE:
  - If div_op = 1 at an edge: load divisor_r = b, quot_r = a, rem_r = 0, count = 0, go to RUN.
  - Otherwise remain in IDLE.
- RUN, one iteration per edge:
  - shifted = {rem_r[15:0], quot_r[15]}, 17 bits.
  - trial = shifted - {1'b0, divisor_r}, 17-bit subtraction.
  - If trial[16] = 0: rem_r = trial and quot_r = {quot_r[14:0], 1'b1}.
  - Else: rem_r = shifted and quot_r = {quot_r[14:0], 1'b0}.
  - count increments. On the edge that completes the 16th iteration (count == 15 beforehand), go to DONE.
- DONE:
  - out = {rem_r[15:0], quot_r}.
  - Remain in DONE while div_op = 1; no restart occurs without passing through IDLE.
- Abort: if div_op = 0 at any edge in RUN or DONE, go to IDLE. The partial result is discarded and out returns to 0 after that edge.
- Operand changes on a/b after the load edge are ignored.
- Divide by zero needs no special path. The algorithm yields quotient = 16'hFFFF and remainder = dividend, with the same latency; the verifier checks exactly these values.
- Arithmetic is unsigned only.
- Invariants:
  - rem_r[16] is always 0 after each iteration.
  - In DONE, remainder < divisor whenever divisor != 0.

## Timing
- Edge 1 with div_op high in IDLE: load.
- Edges 2–17: iterations 1–16.
- ready and a valid out are first high after edge 17, i.e. 17 clocks from the first sampling edge.
- ready and out are combinational from state and op. Both fall in the same cycle op leaves 2'b11, before the IDLE transition edge.
- Back-to-back divides: op must be deasserted for at least one edge (DONE to IDLE). The next load happens on the following edge with div_op high, giving 17 clocks per result plus 1 idle edge.
- Reset asserted mid-RUN: outputs go to 0 immediately, with no edge required. After release, IDLE waits for div_op. If op is still 2'b11, a fresh load occurs on the first edge after release.
- Simultaneous reset and load edge: reset wins and the state stays IDLE.

## Test plan
- Normal divide: a = 100, b = 7, op = 2'b11 held. Expect ready = 0 for 17 edges, then ready = 1 with out = {16'd2, 16'd14} = 32'h0002_000E.
- Extremes: a = 16'hFFFF, b = 1 gives out = 32'h0000_FFFF. Then a = 16'hFFFF, b = 16'hFFFF gives out = 32'h0000_0001.
- Zero and small cases:
  - a = 5, b = 0 gives out = 32'h0005_FFFF after 17 clocks.
  - a = 3, b = 10 gives out = 32'h0003_0000.
  - a = 0, b = 9 gives out = 32'h0.
- Operand stability: load a = 1000, b = 33, then change a and b to random values every cycle during RUN. Expect out = {16'd10, 16'd30}.
- Abort and reset:
  - Drop op to 2'b01 at iteration 8: ready and out go to 0 at once and the state returns to IDLE. Reassert op with a = 50, b = 5: expect out = 32'h0000_000A 17 clocks later.
  - Pulse reset mid-RUN with no clock edge: out and ready are 0 asynchronously.
- Back-to-back: hold op to read a result, deassert op for 1 cycle, then reassert with new operands. Expect the second result exactly 17 clocks after reassertion, with no stale data on out in between.

Source files
------------

// File: rtl/div16.sv
// div16: sequential 16-bit unsigned restoring divider, one quotient bit per clock.
// Revision 1.0 - initial release.
`default_nettype none

module div16 (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  op,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] out,
   output logic        ready
);

   localparam logic [1:0] C_DIV_OP   = 2'b11;
   localparam logic [4:0] C_LAST_ITR = 5'd15;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [4:0]  count_q;
   logic [15:0] divisor_q;
   logic [15:0] quot_q;
   logic [16:0] rem_q;

   logic        div_op;
   logic [16:0] shift_d;
   logic [16:0] trial_d;
   logic        unused_rem_msb;

   assign div_op  = (op == C_DIV_OP);
   assign shift_d = {rem_q[15:0], quot_q[15]};
   assign trial_d = shift_d - {1'b0, divisor_q};

   // rem_q[16] stays zero after every iteration; it only exists as the trial borrow width.
   assign unused_rem_msb = rem_q[16];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         count_q   <= 5'd0;
         divisor_q <= 16'd0;
         quot_q    <= 16'd0;
         rem_q     <= 17'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (div_op) begin
                  divisor_q <= b;
                  quot_q    <= a;
                  rem_q     <= 17'd0;
                  count_q   <= 5'd0;
                  state_q   <= S_RUN;
               end
            end
            S_RUN: begin
               if (!div_op) begin
                  state_q <= S_IDLE;
               end else begin
                  if (!trial_d[16]) begin
                     rem_q  <= trial_d;
                     quot_q <= {quot_q[14:0], 1'b1};
                  end else begin
                     rem_q  <= shift_d;
                     quot_q <= {quot_q[14:0], 1'b0};
                  end
                  count_q <= count_q + 5'd1;
                  if (count_q == C_LAST_ITR) begin
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (!div_op) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Gated by op and reset so both outputs drop without waiting for an edge.
   assign ready = (state_q == S_DONE) & div_op & ~reset;
   assign out   = ready ? {rem_q[15:0], quot_q} : 32'h0;

endmodule

`default_nettype wire
